wide_alu_chunked: RTL and testbench
===================================

Name: wide_alu_chunked

Overview:
- Parametrised, multi-cycle successor of the wide ALU datapath. It processes ALU_WIDTH-bit operands serially in CHUNK_WIDTH slices, with ripple carry between slices.
- Adds a programmable per-slice throttle (deaccel), busy/done handshake, carry output and sticky error reporting.
- Sits behind the register file: config and trigger strobes arrive as write-enable pulses; result/status are read back as hw2reg values.

Parameters:
- ALU_WIDTH, 256: operand and result width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 32: slice processed per active cycle.
- DEACCEL_WIDTH, 8: width of the deaccel factor (stall cycles inserted after each slice).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- trigger_i  in  1  start pulse (qualified write strobe)
- clear_err_i  in  1  clears sticky error
- op_a_i  in  ALU_WIDTH  operand A
- op_b_i  in  ALU_WIDTH  operand B
- op_sel_we_i  in  1  op_sel write strobe
- op_sel_i  in  3  0=ADD 1=SUB 2=XOR 3=AND 4=OR; 5..7 illegal
- deaccel_factor_we_i  in  1  deaccel write strobe
- deaccel_factor_i  in  DEACCEL_WIDTH  stall cycles per slice
- op_sel_o  out  3  current op register
- deaccel_factor_o  out  DEACCEL_WIDTH  current deaccel register
- result_o  out  ALU_WIDTH  last completed result
- carry_o  out  1  final carry of last ADD/SUB; 0 for logic ops
- done_o  out  1  one-cycle completion pulse
- status_o  out  2  {err, busy}

Behaviour:
- Reset (async assert, sync deassert): result_o=0, carry_o=0, op_sel_o=0 (ADD), deaccel_factor_o=0, done_o=0, status_o=0. FSM returns to IDLE. An in-flight operation is discarded; no done pulse.
- NCHUNK = ALU_WIDTH/CHUNK_WIDTH; slice counter is clog2(NCHUNK) bits wide; stall counter is DEACCEL_WIDTH bits wide.
- Config writes:
  - op_sel_we_i / deaccel_factor_we_i load their register on the clock edge, but only in IDLE.
  - While busy, these writes are ignored and the register keeps its value. No error is raised.
  - op_sel writes of 5..7 are stored; the check happens at trigger.
- FSM states are IDLE, CALC, STALL, DONE.
- IDLE + trigger_i with legal op:
  - Latch op_a_i, op_b_i, op_sel and deaccel into shadow registers.
  - slice=0; carry_in = 1 for SUB, 0 otherwise; go to CALC.
- IDLE + trigger_i with illegal op: set err, stay IDLE; result_o and carry_o unchanged.
- CALC:
  - Compute slice[slice] into the internal accumulator.
  - ADD: a+b+cin. SUB: a+~b+cin. XOR/AND/OR are bitwise.
  - Carry propagates to the next slice.
  - If deaccel≠0, go to STALL with count=deaccel. Otherwise advance: the last slice goes to DONE, else slice++ and stay in CALC.
- STALL: decrement count each cycle. On the cycle count reaches 1, advance as in CALC (last slice goes to DONE, else next slice).
- DONE (one cycle):
  - result_o ← accumulator; carry_o ← final carry (ADD/SUB) or 0; done_o=1; go to IDLE.
  - result_o is stable for the whole operation and changes only in DONE.
- Latency: trigger edge to done_o high = NCHUNK*(1+deaccel)+1 cycles. Default with deaccel=0 is 9. Next trigger is accepted the cycle after done_o.
- busy = (state≠IDLE); DONE counts as busy.
- trigger_i while busy: ignored, err set.
- clear_err_i clears err. If clear_err_i and an error-causing event occur in the same cycle, the error wins (err=1).
- clear_err_i together with a legal trigger in IDLE: err cleared and the operation starts.
- SUB carry_o=1 means no borrow (A≥B unsigned). ADD wrap-around is modulo 2^ALU_WIDTH, with carry_o capturing the overflow.
- Operand inputs may change freely after the trigger cycle.

Test Plan:
- Reset, deaccel=0, ADD, A=2^256-1, B=1 -> done_o at cycle 9; result=0, carry_o=1, status 00.
- SUB, A=5, B=7 -> result=2^256-2, carry_o=0. SUB, A=7, B=5 -> result=2, carry_o=1.
- Deaccel write 3, XOR, A=0xF0F0…, B=0xFF00… -> done_o exactly 33 cycles after trigger; result=0x0FF0…; carry_o=0.
- Mid-run trigger and op_sel write of OR during a run -> status_o=11 and the running ADD result is correct. op_sel_o is unchanged. After clear_err_i, status_o=00.
- op_sel=6 then trigger -> no done_o, status_o=10, and the prior result is retained. clear_err_i together with a trigger after writing op_sel=4 -> runs, err=0.
- rst_ni asserted at slice 4 of a run -> all outputs are 0 immediately. After release, a fresh ADD 1+1 gives result=2.

Source files
------------

// File: rtl/wide_alu_chunked_if.sv
// Register-file side bundle of the chunked wide ALU: config/trigger strobes in,
// hw2reg result and status out.
interface wide_alu_chunked_if #(
    parameter int unsigned ALU_WIDTH     = 256,
    parameter int unsigned DEACCEL_WIDTH = 8
);
    logic                     trigger_i;
    logic                     clear_err_i;
    logic [ALU_WIDTH-1:0]     op_a_i;
    logic [ALU_WIDTH-1:0]     op_b_i;
    logic                     op_sel_we_i;
    logic [2:0]               op_sel_i;
    logic                     deaccel_factor_we_i;
    logic [DEACCEL_WIDTH-1:0] deaccel_factor_i;
    logic [2:0]               op_sel_o;
    logic [DEACCEL_WIDTH-1:0] deaccel_factor_o;
    logic [ALU_WIDTH-1:0]     result_o;
    logic                     carry_o;
    logic                     done_o;
    logic [1:0]               status_o;

    modport slave (
        input  trigger_i, clear_err_i, op_a_i, op_b_i, op_sel_we_i, op_sel_i,
               deaccel_factor_we_i, deaccel_factor_i,
        output op_sel_o, deaccel_factor_o, result_o, carry_o, done_o, status_o
    );

    modport master (
        output trigger_i, clear_err_i, op_a_i, op_b_i, op_sel_we_i, op_sel_i,
               deaccel_factor_we_i, deaccel_factor_i,
        input  op_sel_o, deaccel_factor_o, result_o, carry_o, done_o, status_o
    );
endinterface

// File: rtl/wide_alu_chunked.sv
// Multi-cycle wide ALU: processes operands one CHUNK_WIDTH slice per active cycle with
// ripple carry, optional per-slice stall, busy/done handshake and sticky error.
module wide_alu_chunked #(
    parameter int unsigned ALU_WIDTH     = 256,
    parameter int unsigned CHUNK_WIDTH   = 32,
    parameter int unsigned DEACCEL_WIDTH = 8
) (
    input logic               clk_i,
    input logic               rst_ni,
    wide_alu_chunked_if.slave bus
);
    localparam int unsigned NChunk = ALU_WIDTH / CHUNK_WIDTH;
    localparam int unsigned SliceW = (NChunk > 1) ? $clog2(NChunk) : 1;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpXor = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpOr  = 3'd4;

    typedef enum logic [1:0] {StIdle, StCalc, StStall, StDone} state_e;

    state_e                   state_q, state_d;
    logic [2:0]               op_sel_q, op_sel_d;
    logic [DEACCEL_WIDTH-1:0] deaccel_q, deaccel_d;
    logic [2:0]               sh_op_q, sh_op_d;
    logic [DEACCEL_WIDTH-1:0] sh_deaccel_q, sh_deaccel_d;
    logic [ALU_WIDTH-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [ALU_WIDTH-1:0]     result_q, result_d;
    logic [SliceW-1:0]        slice_q, slice_d;
    logic [DEACCEL_WIDTH-1:0] cnt_q, cnt_d;
    logic                     cin_q, cin_d;
    logic                     carry_q, carry_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     busy;
    logic                     is_arith;
    logic                     last_slice;
    logic [CHUNK_WIDTH-1:0]   a_sl, b_sl, b_eff, res_sl;
    logic [CHUNK_WIDTH:0]     sum;

    assign busy       = (state_q != StIdle);
    assign is_arith   = (sh_op_q == OpAdd) || (sh_op_q == OpSub);
    assign last_slice = (slice_q == SliceW'(NChunk - 1));

    // Slice datapath, driven by the shadowed operands so inputs may change mid-run.
    always_comb begin
        a_sl  = a_q[int'(slice_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_sl  = b_q[int'(slice_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_eff = (sh_op_q == OpSub) ? ~b_sl : b_sl;
        sum   = {1'b0, a_sl} + {1'b0, b_eff} + {{CHUNK_WIDTH{1'b0}}, cin_q};
        case (sh_op_q)
            OpAdd, OpSub: res_sl = sum[CHUNK_WIDTH-1:0];
            OpXor:        res_sl = a_sl ^ b_sl;
            OpAnd:        res_sl = a_sl & b_sl;
            OpOr:         res_sl = a_sl | b_sl;
            default:      res_sl = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_sel_d     = op_sel_q;
        deaccel_d    = deaccel_q;
        sh_op_d      = sh_op_q;
        sh_deaccel_d = sh_deaccel_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        result_d     = result_q;
        slice_d      = slice_q;
        cnt_d        = cnt_q;
        cin_d        = cin_q;
        carry_d      = carry_q;
        done_d       = 1'b0;
        err_d        = err_q;

        // A simultaneous error event overrides the clear.
        if (bus.clear_err_i) err_d = 1'b0;
        if (bus.trigger_i && (busy || (op_sel_q > OpOr))) err_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.op_sel_we_i)         op_sel_d  = bus.op_sel_i;
                if (bus.deaccel_factor_we_i) deaccel_d = bus.deaccel_factor_i;
                if (bus.trigger_i && (op_sel_q <= OpOr)) begin
                    a_d          = bus.op_a_i;
                    b_d          = bus.op_b_i;
                    sh_op_d      = op_sel_q;
                    sh_deaccel_d = deaccel_q;
                    slice_d      = '0;
                    cin_d        = (op_sel_q == OpSub);
                    state_d      = StCalc;
                end
            end
            StCalc, StStall: begin
                if (state_q == StCalc) begin
                    acc_d[int'(slice_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = res_sl;
                    cin_d = sum[CHUNK_WIDTH];
                end else begin
                    cnt_d = cnt_q - DEACCEL_WIDTH'(1);
                end
                if ((state_q == StCalc) && (sh_deaccel_q != '0)) begin
                    cnt_d   = sh_deaccel_q;
                    state_d = StStall;
                end else if ((state_q == StCalc) || (cnt_q == DEACCEL_WIDTH'(1))) begin
                    if (last_slice) begin
                        state_d = StDone;
                    end else begin
                        slice_d = slice_q + SliceW'(1);
                        state_d = StCalc;
                    end
                end
            end
            StDone: begin
                result_d = acc_q;
                carry_d  = is_arith ? cin_q : 1'b0;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            op_sel_q     <= OpAdd;
            deaccel_q    <= '0;
            sh_op_q      <= OpAdd;
            sh_deaccel_q <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            slice_q      <= '0;
            cnt_q        <= '0;
            cin_q        <= 1'b0;
            carry_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_sel_q     <= op_sel_d;
            deaccel_q    <= deaccel_d;
            sh_op_q      <= sh_op_d;
            sh_deaccel_q <= sh_deaccel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            slice_q      <= slice_d;
            cnt_q        <= cnt_d;
            cin_q        <= cin_d;
            carry_q      <= carry_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.op_sel_o         = op_sel_q;
    assign bus.deaccel_factor_o = deaccel_q;
    assign bus.result_o         = result_q;
    assign bus.carry_o          = carry_q;
    assign bus.done_o           = done_q;
    assign bus.status_o         = {err_q, busy};
endmodule

// File: tb/tb_wide_alu_chunked.sv
// Self-checking bench for wide_alu_chunked: directed corner cases plus random operations
// compared against a full-width arithmetic reference model.
module tb_wide_alu_chunked;
    localparam int unsigned W  = 256;
    localparam int unsigned CW = 32;
    localparam int unsigned DW = 8;
    localparam int unsigned NC = W / CW;

    typedef logic [W:0] val_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_deaccel = 0;

    wide_alu_chunked_if #(.ALU_WIDTH(W), .DEACCEL_WIDTH(DW)) bus ();

    wide_alu_chunked #(
        .ALU_WIDTH    (W),
        .CHUNK_WIDTH  (CW),
        .DEACCEL_WIDTH(DW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: {carry, result} from whole-operand arithmetic.
    function automatic val_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + val_t'(1);
            3'd2:    return {1'b0, a ^ b};
            3'd3:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    task automatic wr_op(input logic [2:0] op);
        bus.op_sel_i    = op;
        bus.op_sel_we_i = 1'b1;
        tick();
        bus.op_sel_we_i = 1'b0;
    endtask

    task automatic wr_deaccel(input int d);
        bus.deaccel_factor_i    = DW'(d);
        bus.deaccel_factor_we_i = 1'b1;
        tick();
        bus.deaccel_factor_we_i = 1'b0;
        m_deaccel = d;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic clr);
        bus.op_a_i      = a;
        bus.op_b_i      = b;
        bus.trigger_i   = 1'b1;
        bus.clear_err_i = clr;
        tick();
        bus.trigger_i   = 1'b0;
        bus.clear_err_i = 1'b0;
        bus.op_a_i      = rnd();
        bus.op_b_i      = rnd();
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!bus.done_o && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        val_t exp;
        int   lat;
        exp = model(op, a, b);
        launch(a, b, 1'b0);
        check({tag, "_busy"}, val_t'(bus.status_o), val_t'(2'b01));
        wait_done(0, lat);
        check({tag, "_lat"}, val_t'(lat), val_t'(NC * (1 + m_deaccel) + 1));
        check({tag, "_res"}, val_t'(bus.result_o), val_t'(exp[W-1:0]));
        check({tag, "_cy"}, val_t'(bus.carry_o), (op <= 3'd1) ? val_t'(exp[W]) : '0);
        tick();
        check({tag, "_pulse"}, val_t'({bus.done_o, bus.status_o}), '0);
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] pa, pb, prev;
        logic [2:0]   op;
        val_t         exp;
        int           lat;

        rst_n = 1'b0;
        bus.trigger_i = 1'b0; bus.clear_err_i = 1'b0;
        bus.op_a_i = '0; bus.op_b_i = '0;
        bus.op_sel_we_i = 1'b0; bus.op_sel_i = '0;
        bus.deaccel_factor_we_i = 1'b0; bus.deaccel_factor_i = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_res", val_t'(bus.result_o), '0);
        check("rst_misc", val_t'({bus.carry_o, bus.done_o, bus.status_o}), '0);
        check("rst_cfg", val_t'({bus.op_sel_o, bus.deaccel_factor_o}), '0);

        ones = '1;
        run_check("add_wrap", 3'd0, ones, W'(1));
        wr_op(3'd1);
        run_check("sub_5_7", 3'd1, W'(5), W'(7));
        run_check("sub_7_5", 3'd1, W'(7), W'(5));

        wr_deaccel(3);
        check("deaccel_o", val_t'(bus.deaccel_factor_o), val_t'(3));
        wr_op(3'd2);
        for (int i = 0; i < int'(W / 16); i++) begin
            pa[i*16 +: 16] = 16'hF0F0;
            pb[i*16 +: 16] = 16'hFF00;
        end
        run_check("xor_d3", 3'd2, pa, pb);

        for (int n = 0; n < 16; n++) begin
            op = 3'($urandom_range(0, 4));
            wr_op(op);
            wr_deaccel(int'($urandom_range(0, 3)));
            pa = rnd();
            pb = (n % 4 == 0) ? pa : rnd();
            run_check($sformatf("rnd%0d", n), op, pa, pb);
        end

        // Config writes and triggers while busy are dropped and flag an error.
        wr_op(3'd0);
        wr_deaccel(2);
        pa = rnd(); pb = rnd();
        exp = model(3'd0, pa, pb);
        launch(pa, pb, 1'b0);
        tick();
        bus.trigger_i = 1'b1; bus.op_sel_we_i = 1'b1; bus.op_sel_i = 3'd4;
        bus.deaccel_factor_we_i = 1'b1; bus.deaccel_factor_i = 8'd7;
        tick();
        bus.op_sel_we_i = 1'b0; bus.deaccel_factor_we_i = 1'b0; bus.clear_err_i = 1'b1;
        tick();
        bus.trigger_i = 1'b0; bus.clear_err_i = 1'b0;
        check("mid_stat", val_t'(bus.status_o), val_t'(2'b11));
        wait_done(3, lat);
        check("mid_lat", val_t'(lat), val_t'(NC * 3 + 1));
        check("mid_res", val_t'(bus.result_o), val_t'(exp[W-1:0]));
        check("mid_cy", val_t'(bus.carry_o), val_t'(exp[W]));
        check("mid_cfg", val_t'({bus.op_sel_o, bus.deaccel_factor_o}), val_t'({3'd0, 8'd2}));
        tick();
        check("mid_err", val_t'(bus.status_o), val_t'(2'b10));
        bus.clear_err_i = 1'b1;
        tick();
        bus.clear_err_i = 1'b0;
        check("mid_clr", val_t'(bus.status_o), '0);

        // Illegal op: error only, prior result kept.
        wr_deaccel(0);
        prev = bus.result_o;
        wr_op(3'd6);
        launch(rnd(), rnd(), 1'b0);
        wait_done(0, lat);
        check("ill_nodone", val_t'(lat), val_t'(2000));
        check("ill_stat", val_t'(bus.status_o), val_t'(2'b10));
        check("ill_res", val_t'(bus.result_o), val_t'(prev));
        check("ill_opsel", val_t'(bus.op_sel_o), val_t'(3'd6));
        wr_op(3'd4);
        pa = rnd(); pb = rnd();
        launch(pa, pb, 1'b1);
        check("clr_trig", val_t'(bus.status_o), val_t'(2'b01));
        wait_done(0, lat);
        check("clr_lat", val_t'(lat), val_t'(NC + 1));
        check("clr_res", val_t'(bus.result_o), val_t'(pa | pb));
        check("clr_cy", val_t'(bus.carry_o), '0);

        // Asynchronous reset in the middle of a run.
        wr_op(3'd0);
        launch(rnd(), rnd(), 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("arst_res", val_t'(bus.result_o), '0);
        check("arst_misc", val_t'({bus.carry_o, bus.done_o, bus.status_o}), '0);
        check("arst_cfg", val_t'({bus.op_sel_o, bus.deaccel_factor_o}), '0);
        tick(); tick();
        rst_n = 1'b1;
        m_deaccel = 0;
        tick();
        for (int i = 0; i < 12; i++) begin
            check("arst_nodone", val_t'(bus.done_o), '0);
            tick();
        end
        run_check("post_rst", 3'd0, W'(1), W'(1));
        check("post_rst_2", val_t'(bus.result_o), val_t'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
